// File: rtl/rps_pkg.sv
// Shared types and helpers for the rock-paper-scissors player: moves, FSM states,
// LFSR tap set and the LFSR/move conversion functions.
package rps_pkg;

    localparam int unsigned LFSR_W  = 16;
    localparam int unsigned SCORE_W = 32;
    localparam int unsigned COUNT_W = 16;

    // Feedback taps: bits 15, 13, 12 and 10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        MOVE_NONE     = 2'd0,
        MOVE_ROCK     = 2'd1,
        MOVE_PAPER    = 2'd2,
        MOVE_SCISSORS = 2'd3
    } move_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } player_state_e;

    typedef struct packed {
        logic r;
        logic p;
        logic s;
    } rps_onehot_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] state);
        return {state[LFSR_W-2:0], ^(state & LFSR_TAPS)};
    endfunction

    // Two low LFSR bits select the move; the spare code 3 folds onto rock.
    function automatic move_e lfsr_to_move(input logic [1:0] low_bits);
        move_e m;
        case (low_bits)
            2'd1:    m = MOVE_PAPER;
            2'd2:    m = MOVE_SCISSORS;
            default: m = MOVE_ROCK;
        endcase
        return m;
    endfunction

    function automatic rps_onehot_t move_to_onehot(input move_e m);
        rps_onehot_t oh;
        oh = '0;
        case (m)
            MOVE_ROCK:     oh.r = 1'b1;
            MOVE_PAPER:    oh.p = 1'b1;
            MOVE_SCISSORS: oh.s = 1'b1;
            default:       oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/rps_lfsr.sv
// 16-bit Fibonacci LFSR that steps once per advance strobe; a zero seed
// would lock up, so it is replaced by 1 at reset.
module rps_lfsr
    import rps_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_advance,
    output logic [LFSR_W-1:0] o_state
);

    localparam logic [LFSR_W-1:0] RESET_STATE = (SEED == '0) ? LFSR_W'(1) : SEED;

    logic [LFSR_W-1:0] r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RESET_STATE;
        end else if (i_advance) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/rps_player.sv
// Rock-paper-scissors round initiator: requests rounds from the referee with
// LFSR-chosen moves. Define RPS_PLAYER_ADAPT_EN for win-stay/lose-shift play.
module rps_player
    import rps_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
    parameter int unsigned       ROUNDS  = 16,
    parameter int unsigned       GAP     = 2,
    parameter int unsigned       TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               dut_busy,
    input  logic [SCORE_W-1:0] score,
    output logic               r,
    output logic               p,
    output logic               s,
    output logic               go,
    output logic [COUNT_W-1:0] rounds_played,
    output logic               done,
    output logic               timeout_err
);

    localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned GAP_LAST = (GAP == 0) ? 0 : GAP - 1;
    localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    player_state_e      r_state,   w_state_d;
    logic               r_go,      w_go_d;
    rps_onehot_t        r_rps,     w_rps_d;
    logic [COUNT_W-1:0] r_rounds,  w_rounds_d;
    logic               r_done,    w_done_d;
    logic               r_tmo_err, w_tmo_err_d;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_d;
    logic [TMO_W-1:0]   r_tmo_cnt, w_tmo_d;
    logic               w_launch;
    logic [LFSR_W-1:0]  w_lfsr_state;
    rps_onehot_t        w_lfsr_rps;
    rps_onehot_t        w_next_rps;

    rps_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .i_advance (w_launch),
        .o_state   (w_lfsr_state)
    );

    // Move is taken from the low bits of the value the LFSR steps to on launch.
    assign w_lfsr_rps = move_to_onehot(lfsr_to_move({w_lfsr_state[0],
                                                     ^(w_lfsr_state & LFSR_TAPS)}));

`ifdef RPS_PLAYER_ADAPT_EN
    logic [SCORE_W-1:0] r_prev_score;
    logic               r_win;
    logic               w_win;
    rps_onehot_t        r_last_rps;

    // Score is live in SETTLE, so a GAP=0 relaunch must see this round's result.
    assign w_win      = (r_state == ST_SETTLE) ? ($signed(score) > $signed(r_prev_score)) : r_win;
    assign w_next_rps = w_win ? r_last_rps : w_lfsr_rps;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_score <= '0;
            r_win        <= 1'b0;
            r_last_rps   <= '0;
        end else begin
            if (r_state == ST_SETTLE) begin
                r_prev_score <= score;
                r_win        <= w_win;
            end
            if (w_launch) begin
                r_last_rps <= w_next_rps;
            end
        end
    end
`else
    logic w_unused_score;
    assign w_unused_score = ^score;
    assign w_next_rps     = w_lfsr_rps;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_go      <= 1'b0;
            r_rps     <= '0;
            r_rounds  <= '0;
            r_done    <= 1'b0;
            r_tmo_err <= 1'b0;
            r_gap_cnt <= '0;
            r_tmo_cnt <= '0;
        end else begin
            r_state   <= w_state_d;
            r_go      <= w_go_d;
            r_rps     <= w_rps_d;
            r_rounds  <= w_rounds_d;
            r_done    <= w_done_d;
            r_tmo_err <= w_tmo_err_d;
            r_gap_cnt <= w_gap_d;
            r_tmo_cnt <= w_tmo_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_go_d      = r_go;
        w_rps_d     = r_rps;
        w_rounds_d  = r_rounds;
        w_done_d    = r_done;
        w_tmo_err_d = r_tmo_err;
        w_gap_d     = r_gap_cnt;
        w_tmo_d     = r_tmo_cnt;
        w_launch    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (enable && !r_done) begin
                    w_launch = 1'b1;
                end
            end
            ST_REQ: begin
                if (dut_busy) begin
                    w_state_d = ST_WAIT;
                    w_go_d    = 1'b0;
                    w_rps_d   = '0;
                    w_tmo_d   = '0;
                end else if (r_tmo_cnt == TMO_W'(TMO_LAST)) begin
                    w_state_d   = ST_ERR;
                    w_go_d      = 1'b0;
                    w_rps_d     = '0;
                    w_tmo_err_d = 1'b1;
                end else begin
                    w_tmo_d = r_tmo_cnt + TMO_W'(1);
                end
            end
            ST_WAIT: begin
                if (!dut_busy) begin
                    w_state_d = ST_SETTLE;
                    if (r_rounds != '1) begin
                        w_rounds_d = r_rounds + COUNT_W'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if ((ROUNDS != 0) && (r_rounds == COUNT_W'(ROUNDS))) begin
                    w_state_d = ST_DONE;
                    w_done_d  = 1'b1;
                end else if (GAP != 0) begin
                    w_state_d = ST_GAP;
                    w_gap_d   = '0;
                end else if (enable) begin
                    w_launch = 1'b1;
                end else begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (!enable) begin
                    w_state_d = ST_IDLE;
                end else if (r_gap_cnt == GAP_W'(GAP_LAST)) begin
                    w_launch = 1'b1;
                end else begin
                    w_gap_d = r_gap_cnt + GAP_W'(1);
                end
            end
            ST_DONE, ST_ERR: begin
                w_go_d  = 1'b0;
                w_rps_d = '0;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // Every route into REQ loads the move, raises go and restarts the timeout.
        if (w_launch) begin
            w_state_d = ST_REQ;
            w_go_d    = 1'b1;
            w_rps_d   = w_next_rps;
            w_tmo_d   = '0;
        end
    end

    assign r             = r_rps.r;
    assign p             = r_rps.p;
    assign s             = r_rps.s;
    assign go            = r_go;
    assign rounds_played = r_rounds;
    assign done          = r_done;
    assign timeout_err   = r_tmo_err;

endmodule
